fifo_burst_reader: RTL
======================

Name: fifo_burst_reader

Overview:
Downstream consumer of the line-buffer fill controller. Each go_fill_fifo pulse (with ddr_addr_to_read) becomes one fixed-length DDR burst read on the PLB master IPIF read channel. Returned words are pushed into the HDMI line FIFO under full-flag back-pressure. A small pending-request queue absorbs go pulses that arrive while a burst is still in flight.

Parameters:
BURST_WORDS, 64, words per burst (half line FIFO); power of two, 2..256
DATA_WIDTH, 32, bus/FIFO data width in bits; fixed 32 in this revision
PEND_DEPTH, 2, pending go-request queue depth; 1..4

Ports:
Bus2IP_Clk  in  1  system clock
Bus2IP_Resetn  in  1  synchronous active-low reset
go_fill_fifo  in  1  single-cycle burst request from the fill controller
ddr_addr_to_read  in  32  byte address, sampled when go_fill_fifo=1
IP2Bus_MstRd_Req  out  1  master read command request
IP2Bus_Mst_Addr  out  32  burst start address, word-aligned
IP2Bus_Mst_Length  out  12  burst length in bytes = BURST_WORDS*4
Bus2IP_Mst_CmdAck  in  1  command accepted
Bus2IP_Mst_Cmplt  in  1  burst complete
Bus2IP_Mst_Error  in  1  burst error, qualified by Cmplt
Bus2IP_MstRd_d  in  32  read data
Bus2IP_MstRd_src_rdy_n  in  1  read data valid, active-low
IP2Bus_MstRd_dst_rdy_n  out  1  read data accept, active-low
fifo_wr_en  out  1  line FIFO write strobe
fifo_wr_data  out  32  line FIFO write data
fifo_full  in  1  line FIFO full
busy  out  1  burst in flight or queue non-empty
err_sticky  out  1  bus error or short burst seen since reset
ovf_sticky  out  1  go pulse dropped because the queue was full

Behaviour:
- Reset: when Bus2IP_Resetn=0 at a clock edge, the following are cleared: FSM to IDLE, queue flushed, beat counter 0, all outputs 0, IP2Bus_MstRd_dst_rdy_n=1. Reset mid-burst abandons the burst; no further FIFO writes occur.
- Queue: FIFO of addresses, PEND_DEPTH entries.
  - go_fill_fifo=1 with queue not full: push {ddr_addr_to_read[31:2],2'b00}.
  - go_fill_fifo=1 with queue full: drop the request and set ovf_sticky.
  - Push and pop in the same cycle are both honoured.
- FSM states: IDLE, REQ, DATA, CMPLT.
  - IDLE: if queue not empty, pop into addr_reg, beat counter := 0, go to REQ next cycle. A go pulse into an empty queue in IDLE reaches REQ 2 cycles later.
  - REQ: IP2Bus_MstRd_Req=1. IP2Bus_Mst_Addr=addr_reg and Length=BURST_WORDS*4 are held stable. On Bus2IP_Mst_CmdAck=1, go to DATA. Req deasserts in the cycle after CmdAck.
  - DATA: IP2Bus_MstRd_dst_rdy_n = fifo_full.
    - Beat = src_rdy_n=0 and dst_rdy_n=0.
    - On each beat, combinationally in the same cycle: fifo_wr_en=1, fifo_wr_data=Bus2IP_MstRd_d; counter increments.
    - Never writes while fifo_full=1.
    - After beat BURST_WORDS, go to CMPLT, or directly to IDLE if Cmplt=1 in the same cycle.
  - CMPLT: wait for Bus2IP_Mst_Cmplt, then go to IDLE. dst_rdy_n=1. Extra beats are ignored and not written.
- Errors: Cmplt with Error=1 in any state sets err_sticky. Cmplt in DATA with count<BURST_WORDS (short burst) also sets err_sticky. Either case goes to IDLE without writing the remaining beats (unless BURST_PAD_EN).
- Sticky flags clear only on reset.
- busy = (state!=IDLE) | queue non-empty.
- Counter width: clog2(BURST_WORDS)+1 bits; no wrap within a burst.
- Address is passed through unmodified; no arithmetic, and 32-bit wrap is the caller's concern.

Optional Feature:
BURST_PAD_EN
- Defined: on error or short burst, a PAD state writes 32'h0000_0000 to the FIFO, one word per cycle while fifo_full=0, until BURST_WORDS total words have been written for the burst, then goes to IDLE. This keeps line/pixel alignment. err_sticky is still set.
- Undefined: no PAD state; truncated bursts leave the FIFO short.

Test Plan:
- Single burst: go with addr 0x1000_0003 → Req with Addr 0x1000_0000, Length 0x100. CmdAck, then 64 back-to-back beats with data 0..63 → 64 fifo_wr_en with data 0..63; busy drops 1 cycle after Cmplt.
- Back-pressure: fifo_full=1 for beats 10–19 → dst_rdy_n=1 on those cycles, no writes while full; exactly 64 words, in order.
- Queueing: 3 go pulses (0x0, 0x100, 0x200) during burst 1 with PEND_DEPTH=2 → bursts at 0x0 and 0x100 (queued), third pulse dropped, ovf_sticky=1.
- Error: Cmplt+Error after 20 beats → err_sticky=1, 20 writes (64 with BURST_PAD_EN, last 44 zero), FSM returns to IDLE.
- Reset mid-DATA after 30 beats → next cycle all outputs 0, queue empty; a subsequent go starts a fresh 64-beat burst.
- Simultaneous: go pulse in the same cycle IDLE pops the last entry → both handled; two bursts issued in order.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: turns go_fill_fifo requests into fixed-length PLB master burst reads and streams the words into the HDMI line FIFO; optional BURST_PAD_EN zero-fills truncated bursts.
// Latency: a go pulse into an idle, empty block raises IP2Bus_MstRd_Req 2 cycles later; data is written through combinationally; fifo_full holds dst_rdy_n high.

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module fifo_burst_reader #(
  parameter int BURST_WORDS = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int PEND_DEPTH  = 2
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Resetn,
  input  logic                  go_fill_fifo,
  input  logic [31:0]           ddr_addr_to_read,
  output logic                  IP2Bus_MstRd_Req,
  output logic [31:0]           IP2Bus_Mst_Addr,
  output logic [11:0]           IP2Bus_Mst_Length,
  input  logic                  Bus2IP_Mst_CmdAck,
  input  logic                  Bus2IP_Mst_Cmplt,
  input  logic                  Bus2IP_Mst_Error,
  input  logic [DATA_WIDTH-1:0] Bus2IP_MstRd_d,
  input  logic                  Bus2IP_MstRd_src_rdy_n,
  output logic                  IP2Bus_MstRd_dst_rdy_n,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic                  err_sticky,
  output logic                  ovf_sticky
);
  localparam int               CNT_W       = $clog2(BURST_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(BURST_WORDS);
  localparam logic [11:0]      BURST_BYTES = 12'(BURST_WORDS * 4);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CMPLT = 3'd3,
    ST_PAD   = 3'd4
  } state_t;

`ifdef BURST_PAD_EN
  localparam state_t ST_TRUNC = ST_PAD;
`else
  localparam state_t ST_TRUNC = ST_IDLE;
`endif

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [31:0]           addr_reg;
  logic [31:0]           q_head;
  logic                  q_full;
  logic                  q_empty;
  logic                  q_pop;
  logic                  load_addr;
  logic                  err_set;
  logic                  beat;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  req;
  logic                  dst_rdy_n;

  // Byte offset bits are masked here so the queue only ever holds word-aligned addresses.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (PEND_DEPTH)
  ) u_pend_q (
    .clk      (Bus2IP_Clk),
    .rst_n    (Bus2IP_Resetn),
    .push_vld (go_fill_fifo),
    .push_dat (ddr_addr_to_read & 32'hFFFF_FFFC),
    .pop_rdy  (q_pop),
    .head_dat (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_pop     = 1'b0;
    load_addr = 1'b0;
    req       = 1'b0;
    dst_rdy_n = 1'b1;
    beat      = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    err_set   = Bus2IP_Mst_Cmplt && Bus2IP_Mst_Error;

    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          load_addr = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (Bus2IP_Mst_Cmplt && Bus2IP_Mst_Error) begin
          state_nxt = ST_TRUNC;
        end else if (Bus2IP_Mst_CmdAck) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        dst_rdy_n = fifo_full;
        beat      = !Bus2IP_MstRd_src_rdy_n && !fifo_full;
        if (beat) begin
          wr_en   = 1'b1;
          wr_data = Bus2IP_MstRd_d;
          cnt_nxt = cnt + 1'b1;
        end
        if (cnt_nxt == LAST_CNT) begin
          state_nxt = Bus2IP_Mst_Cmplt ? ST_IDLE : ST_CMPLT;
        end else if (Bus2IP_Mst_Cmplt) begin
          err_set   = 1'b1;
          state_nxt = ST_TRUNC;
        end
      end
      ST_CMPLT: begin
        if (Bus2IP_Mst_Cmplt) state_nxt = ST_IDLE;
      end
`ifdef BURST_PAD_EN
      ST_PAD: begin
        if (!fifo_full) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + 1'b1;
        end
        if (cnt_nxt == LAST_CNT) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_reg   <= '0;
      err_sticky <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_addr)               addr_reg   <= q_head;
      if (err_set)                 err_sticky <= 1'b1;
      if (go_fill_fifo && q_full)  ovf_sticky <= 1'b1;
    end
  end

  // Writes are gated by reset so an abandoned burst cannot leak a word in the reset cycle.
  assign fifo_wr_en             = wr_en && Bus2IP_Resetn;
  assign fifo_wr_data           = fifo_wr_en ? wr_data : '0;
  assign IP2Bus_MstRd_Req       = req;
  assign IP2Bus_Mst_Addr        = addr_reg;
  assign IP2Bus_Mst_Length      = (state == ST_REQ) ? BURST_BYTES : 12'd0;
  assign IP2Bus_MstRd_dst_rdy_n = dst_rdy_n;
  assign busy                   = (state != ST_IDLE) || !q_empty;
endmodule
